// File: rtl/ddio.sv
// Double-data-rate input capture: each lane is sampled on both edges of inclock
// and the pair is presented together, aligned to the rising edge.
module ddio #(
  parameter int unsigned        WIDTH      = 8,
  parameter logic [WIDTH-1:0]   INIT_VALUE = '0
) (
  input  logic             inclock,
  input  logic             sclr,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout_h,
  output logic [WIDTH-1:0] dataout_l
);

  // Power-up values come from the declaration initialisers below.
  logic [WIDTH-1:0] cap_l_q = INIT_VALUE;
  logic [WIDTH-1:0] out_h_q = INIT_VALUE;
  logic [WIDTH-1:0] out_l_q = INIT_VALUE;

  logic [WIDTH-1:0] cap_l_d;
  logic [WIDTH-1:0] out_h_d;
  logic [WIDTH-1:0] out_l_d;

  // Reset takes priority over capture on every register.
  always_comb begin
    cap_l_d = datain;
    out_h_d = datain;
    out_l_d = cap_l_q;
    if (sclr) begin
      cap_l_d = INIT_VALUE;
      out_h_d = INIT_VALUE;
      out_l_d = INIT_VALUE;
    end
  end

  // The falling-edge sample sits in cap_l for half a cycle, then joins
  // the rising-edge sample so the pair is presented together.
  always_ff @(negedge inclock) begin
    cap_l_q <= cap_l_d;
  end

  always_ff @(posedge inclock) begin
    out_h_q <= out_h_d;
    out_l_q <= out_l_d;
  end

  assign dataout_h = out_h_q;
  assign dataout_l = out_l_q;

endmodule

// File: tb/tb_ddio.sv
// Directed bench for ddio: stimulus pushes expected (l,h) pairs tagged by edge
// number; a monitor pops and compares them just after each inclock edge.
module tb_ddio;

  localparam int W = 8;

  bit           inclock;
  logic         sclr;
  logic [W-1:0] datain;
  logic [W-1:0] dataout_h;
  logic [W-1:0] dataout_l;

  ddio #(.WIDTH(W), .INIT_VALUE('0)) dut (
    .inclock  (inclock),
    .sclr     (sclr),
    .datain   (datain),
    .dataout_h(dataout_h),
    .dataout_l(dataout_l)
  );

  typedef struct {
    int           tag;
    logic [W-1:0] el;
    logic [W-1:0] eh;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   sh     = 0;   // stimulus edge count
  int   mh     = 0;   // monitor edge count

  // Rising edges at odd edge numbers (t=5,15,...), falling at even.
  initial begin
    forever #5 inclock = ~inclock;
  end

  task automatic check_entry(input exp_t e);
    checks++;
    if (dataout_l === e.el && dataout_h === e.eh) begin
      passes++;
      $display("check %-10s edge %0d: l=%h h=%h ok", e.name, e.tag, dataout_l, dataout_h);
    end else begin
      $display("FAIL %s edge %0d: got l=%h h=%h, expected l=%h h=%h",
               e.name, e.tag, dataout_l, dataout_h, e.el, e.eh);
    end
  endtask

  // Monitor
  initial begin
    #1;
    while (exp_q.size() > 0 && exp_q[0].tag == 0) check_entry(exp_q.pop_front());
    forever begin
      @(inclock);
      mh++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].tag == mh) check_entry(exp_q.pop_front());
    end
  end

  // Wait for the next edge, then set up what the following edge samples.
  task automatic half(input logic [W-1:0] v, input logic r);
    @(inclock);
    sh++;
    #2;
    datain = v;
    sclr   = r;
  endtask

  // Expect outputs just after the next edge.
  task automatic expect_next(input logic [W-1:0] el, input logic [W-1:0] eh, input string name);
    exp_t e;
    e.tag  = sh + 1;
    e.el   = el;
    e.eh   = eh;
    e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e0;
    datain = '0;
    sclr   = 1'b0;
    e0.tag = 0; e0.el = 8'h00; e0.eh = 8'h00; e0.name = "powerup";
    exp_q.push_back(e0);

    // A5 in the low phase, 3C in the high phase
    half(8'hA5, 1'b0);
    half(8'h3C, 1'b0); expect_next(8'hA5, 8'h3C, "pair");

    // Alternating stream 01..04 starting on a fall
    half(8'h01, 1'b0);
    half(8'h02, 1'b0); expect_next(8'h01, 8'h02, "stream1");
    half(8'h03, 1'b0);
    half(8'h04, 1'b0); expect_next(8'h03, 8'h04, "stream2");

    // Outputs hold across a falling edge and datain changes
    half(8'h77, 1'b0); expect_next(8'h03, 8'h04, "hold_fall");
    #1 datain = 8'hEE;
    #1 datain = 8'h77;
    half(8'h88, 1'b0); expect_next(8'h77, 8'h88, "after_hold");

    // One-rising-edge reset mid-stream, then release
    half(8'h11, 1'b0); expect_next(8'h77, 8'h88, "hold_fall2");
    half(8'h22, 1'b1); expect_next(8'h00, 8'h00, "reset_rise");
    half(8'h33, 1'b0);
    half(8'h44, 1'b0); expect_next(8'h33, 8'h44, "release");

    // Reset seen only at a falling edge clears the low capture
    half(8'h55, 1'b1);
    half(8'h66, 1'b0); expect_next(8'h00, 8'h66, "reset_fall");

    // Lane independence: only bit 5 toggles
    half(8'h20, 1'b0);
    half(8'h00, 1'b0); expect_next(8'h20, 8'h00, "lane5_a");
    half(8'h00, 1'b0);
    half(8'h20, 1'b0); expect_next(8'h00, 8'h20, "lane5_b");
    half(8'h20, 1'b0);
    half(8'h20, 1'b0); expect_next(8'h20, 8'h20, "lane5_c");

    half(8'h00, 1'b0);
    repeat (4) @(inclock);
    #3;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      $display("FAIL %s edge %0d: never checked, expected l=%h h=%h", e.name, e.tag, e.el, e.eh);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks done", passes, checks);
    $fatal(1);
  end

endmodule
